uart_msg_deframer: RTL and testbench
====================================

// Module: uart_msg_deframer
// PURPOSE
//  Assembles received UART words into fixed-width host messages, splits each into header and payload.
//  Sits between uart_rx and the message decoder in the harness.
//  Successor to the fixed 8x8-bit assembler: parametrised widths, inter-word timeout resync,
//  valid/ready output with overflow reporting, optional checksum word.
// PARAMETERS
//  DATA_WIDTH    8       bits per UART word
//  MSG_WIDTH     64      message bits; must be an integer multiple of DATA_WIDTH
//  HEADER_WIDTH  8       header bits, taken from msg[MSG_WIDTH-1 -: HEADER_WIDTH]
//  TIMEOUT_CLKS  168750  idle clocks allowed between words of one message (2 words @9600 baud, 81MHz)
// PORTS
//  clk_in          in   1                         system clock
//  rst_in          in   1                         synchronous reset, active high
//  in_data         in   DATA_WIDTH                received word
//  in_valid        in   1                         1-cycle strobe, in_data valid
//  msg_header      out  HEADER_WIDTH              header of held message
//  msg_payload     out  MSG_WIDTH-HEADER_WIDTH    payload, msg[MSG_WIDTH-HEADER_WIDTH-1:0]
//  msg_valid       out  1                         message held, stable until accepted
//  msg_ready       in   1                         consumer accepts when msg_valid & msg_ready
//  overflow_pulse  out  1                         word dropped because a message was held
//  timeout_pulse   out  1                         partial message discarded on timeout
//  csum_err_pulse  out  1                         checksum mismatch, message discarded
// BEHAVIOUR
//  - Clock and reset: one clock, clk_in; rst_in is synchronous and active high.
//  - WORDS = MSG_WIDTH/DATA_WIDTH. Word k (0-based, in arrival order) lands in msg[k*DATA_WIDTH +: DATA_WIDTH] (LSW first).
//  - Reset: state IDLE, word count 0, shift register 0, timer 0, all outputs 0. Reset mid-message discards all data.
//  - States: IDLE -> COLLECT on first word; COLLECT -> HOLD when word WORDS-1 is accepted
//    (or CHECK, if enabled); HOLD -> IDLE on handshake.
//  - Latency: msg_valid rises the cycle after the last word's in_valid.
//  - msg_header/msg_payload are stable while msg_valid=1. They are don't-care otherwise.
//  - In HOLD, in_valid without a same-cycle handshake: word dropped, overflow_pulse=1 for 1 cycle.
//  - In HOLD, in_valid in the same cycle as a handshake: the message is consumed and the word becomes word 0 of the next message (state COLLECT).
//  - Timer: cleared on every accepted word, counts in COLLECT/CHECK only, saturates.
//    At count TIMEOUT_CLKS-1 with no in_valid: go to IDLE, clear count, timeout_pulse=1 for 1 cycle.
//  - Word and timeout expiry in the same cycle: the word wins and the timer clears.
//  - The timer is inactive in IDLE and HOLD. A held message never times out.
//  - Word counter width is $clog2(WORDS+1). It wraps to 0 only on completion, timeout or reset.
//  - All pulse outputs are registered and last exactly 1 cycle.
// CONFIGURATION
//  UART_MSG_DEFRAMER_CHECKSUM_EN defined:
//   - After WORDS data words, state CHECK expects one extra word equal to the XOR of all WORDS words.
//   - Match: go to HOLD, msg_valid the next cycle.
//   - Mismatch: go to IDLE, discard, csum_err_pulse=1 for 1 cycle.
//   - The timeout also applies in CHECK.
//  Not defined: no CHECK state, no extra word; csum_err_pulse is tied 0.
// TESTING
//  (defaults, clk 81MHz; words fed as in_valid strobes)
//  1 send 01..08 -> msg_valid 1 cycle after 8th word; header=08, payload=07060504030201; hold until msg_ready
//  2 send 3 words, idle TIMEOUT_CLKS cycles -> timeout_pulse once; then 8 fresh words -> correct new message
//  3 complete msg, msg_ready=0, send AA -> overflow_pulse, held msg unchanged; AA in handshake cycle -> word 0 of next msg
//  4 assert rst_in after 5 words -> all outputs 0; next 8 words form a clean message
//  5 CHECKSUM_EN: 01..08 + 08 -> msg_valid; 01..08 + 00 -> csum_err_pulse, no msg_valid
//  6 DATA_WIDTH=16, MSG_WIDTH=64, HEADER_WIDTH=16: 4 words 1111,2222,3333,4444 -> header=4444, payload=333322221111

Source files
------------

// File: rtl/uart_msg_deframer.sv
// uart_msg_deframer
//   Collects received UART words into one fixed-width host message and presents
//   it split into header and payload. Sits between uart_rx and the message
//   decoder.
//
//   Words arrive LSW first: word k of a message lands in
//   msg[k*DATA_WIDTH +: DATA_WIDTH]. The header is the top HEADER_WIDTH bits of
//   the message, the payload is everything below it.
//
//   Output handshake: msg_valid rises the cycle after the last word is taken
//   and stays high, with msg_header/msg_payload stable, until a cycle in which
//   msg_valid & msg_ready are both high. That cycle consumes the message.
//   msg_header/msg_payload are don't-care while msg_valid is low.
//
//   Optional feature (macro UART_MSG_DEFRAMER_CHECKSUM_EN): after the data words
//   one extra word must equal the XOR of all data words. A match presents the
//   message; a mismatch discards it and pulses csum_err_pulse. Without the
//   macro there is no checksum word and csum_err_pulse is tied low.
//
// Ports
//   clk_in          in   system clock
//   rst_in          in   synchronous reset, active high
//   in_data         in   received word
//   in_valid        in   1-cycle strobe, in_data valid
//   msg_header      out  header of the held message
//   msg_payload     out  payload of the held message
//   msg_valid       out  message held, stable until accepted
//   msg_ready       in   consumer accepts when msg_valid & msg_ready
//   overflow_pulse  out  word dropped because a message was held
//   timeout_pulse   out  partial message discarded after inter-word timeout
//   csum_err_pulse  out  checksum mismatch, message discarded
//
// MSG_WIDTH must be an integer multiple of DATA_WIDTH, and HEADER_WIDTH must be
// smaller than MSG_WIDTH.

module uart_msg_deframer #(
    parameter int DATA_WIDTH   = 8,
    parameter int MSG_WIDTH    = 64,
    parameter int HEADER_WIDTH = 8,
    parameter int TIMEOUT_CLKS = 168750
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_valid,
    output logic [HEADER_WIDTH-1:0]           msg_header,
    output logic [MSG_WIDTH-HEADER_WIDTH-1:0] msg_payload,
    output logic                              msg_valid,
    input  logic                              msg_ready,
    output logic                              overflow_pulse,
    output logic                              timeout_pulse,
    output logic                              csum_err_pulse
);

    localparam int WORDS = MSG_WIDTH / DATA_WIDTH;
    localparam int CW    = $clog2(WORDS + 1);
    // The timer never needs to hold more than TIMEOUT_CLKS-1.
    localparam int TW    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [CW-1:0] LAST_IDX   = CW'(WORDS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_CHECK   = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t                 state;
    logic [CW-1:0]          word_cnt;
    logic [MSG_WIDTH-1:0]   shreg;
    logic [TW-1:0]          timer;

    logic [MSG_WIDTH-1:0]   shifted;
    logic                   take_word;
    logic                   first_word;
    logic [CW-1:0]          cur_idx;
    logic                   last_word;

`ifdef UART_MSG_DEFRAMER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]  csum;
`endif

    assign msg_header  = shreg[MSG_WIDTH-1 -: HEADER_WIDTH];
    assign msg_payload = shreg[MSG_WIDTH-HEADER_WIDTH-1:0];

    // New words enter at the top and move down, so after WORDS words the
    // first one sits in the least significant slot.
    always_comb begin
        shifted = shreg >> DATA_WIDTH;
        shifted[MSG_WIDTH-1 -: DATA_WIDTH] = in_data;
    end

    // A word is taken as data when idle, while collecting, or in the very
    // cycle the held message is handed off (it then starts the next message).
    always_comb begin
        take_word  = in_valid && ((state == S_IDLE) || (state == S_COLLECT) ||
                                  ((state == S_HOLD) && msg_ready));
        first_word = (state != S_COLLECT);
        cur_idx    = first_word ? '0 : word_cnt;
        last_word  = take_word && (cur_idx == LAST_IDX);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= S_IDLE;
            word_cnt       <= '0;
            shreg          <= '0;
            timer          <= '0;
            msg_valid      <= 1'b0;
            overflow_pulse <= 1'b0;
            timeout_pulse  <= 1'b0;
`ifdef UART_MSG_DEFRAMER_CHECKSUM_EN
            csum           <= '0;
            csum_err_pulse <= 1'b0;
`endif
        end else begin
            overflow_pulse <= 1'b0;
            timeout_pulse  <= 1'b0;
`ifdef UART_MSG_DEFRAMER_CHECKSUM_EN
            csum_err_pulse <= 1'b0;
`endif
            if (take_word) begin
                // A word always beats a same-cycle timeout expiry.
                shreg <= shifted;
                timer <= '0;
`ifdef UART_MSG_DEFRAMER_CHECKSUM_EN
                csum  <= first_word ? in_data : (csum ^ in_data);
`endif
                if (last_word) begin
                    word_cnt  <= '0;
`ifdef UART_MSG_DEFRAMER_CHECKSUM_EN
                    state     <= S_CHECK;
                    msg_valid <= 1'b0;
`else
                    state     <= S_HOLD;
                    msg_valid <= 1'b1;
`endif
                end else begin
                    word_cnt  <= cur_idx + 1'b1;
                    state     <= S_COLLECT;
                    msg_valid <= 1'b0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        timer <= '0;
                    end
                    S_COLLECT: begin
                        if (timer == TIMER_LAST) begin
                            state         <= S_IDLE;
                            word_cnt      <= '0;
                            timer         <= '0;
                            timeout_pulse <= 1'b1;
                        end else if (timer != '1) begin
                            timer <= timer + 1'b1;
                        end
                    end
`ifdef UART_MSG_DEFRAMER_CHECKSUM_EN
                    S_CHECK: begin
                        if (in_valid) begin
                            timer <= '0;
                            if (in_data == csum) begin
                                state     <= S_HOLD;
                                msg_valid <= 1'b1;
                            end else begin
                                state          <= S_IDLE;
                                csum_err_pulse <= 1'b1;
                            end
                        end else if (timer == TIMER_LAST) begin
                            state         <= S_IDLE;
                            timer         <= '0;
                            timeout_pulse <= 1'b1;
                        end else if (timer != '1) begin
                            timer <= timer + 1'b1;
                        end
                    end
`endif
                    S_HOLD: begin
                        timer <= '0;
                        if (msg_ready) begin
                            msg_valid <= 1'b0;
                            state     <= S_IDLE;
                        end else if (in_valid) begin
                            overflow_pulse <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        word_cnt <= '0;
                        timer    <= '0;
                    end
                endcase
            end
        end
    end

`ifndef UART_MSG_DEFRAMER_CHECKSUM_EN
    assign csum_err_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uart_msg_deframer.sv
// tb_uart_msg_deframer
//   Directed bench for uart_msg_deframer. One instance uses 8-bit words with a
//   short timeout so the timeout path fits in a short run; a second instance
//   uses 16-bit words and a 16-bit header. When UART_MSG_DEFRAMER_CHECKSUM_EN
//   is defined every message is followed by its XOR word and the checksum
//   sequences are exercised as well.

module tb_uart_msg_deframer;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        msg_ready = 1'b0;
    logic [7:0]  msg_header;
    logic [55:0] msg_payload;
    logic        msg_valid;
    logic        overflow_pulse;
    logic        timeout_pulse;
    logic        csum_err_pulse;

    logic [15:0] in_data16 = '0;
    logic        in_valid16 = 1'b0;
    logic        msg_ready16 = 1'b0;
    logic [15:0] msg_header16;
    logic [47:0] msg_payload16;
    logic        msg_valid16;
    logic        overflow_pulse16;
    logic        timeout_pulse16;
    logic        csum_err_pulse16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_msg_deframer #(
        .DATA_WIDTH(8), .MSG_WIDTH(64), .HEADER_WIDTH(8), .TIMEOUT_CLKS(TO)
    ) u_dut (
        .clk_in(clk), .rst_in(rst),
        .in_data(in_data), .in_valid(in_valid),
        .msg_header(msg_header), .msg_payload(msg_payload),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .overflow_pulse(overflow_pulse), .timeout_pulse(timeout_pulse),
        .csum_err_pulse(csum_err_pulse)
    );

    uart_msg_deframer #(
        .DATA_WIDTH(16), .MSG_WIDTH(64), .HEADER_WIDTH(16), .TIMEOUT_CLKS(TO)
    ) u_dut16 (
        .clk_in(clk), .rst_in(rst),
        .in_data(in_data16), .in_valid(in_valid16),
        .msg_header(msg_header16), .msg_payload(msg_payload16),
        .msg_valid(msg_valid16), .msg_ready(msg_ready16),
        .overflow_pulse(overflow_pulse16), .timeout_pulse(timeout_pulse16),
        .csum_err_pulse(csum_err_pulse16)
    );

    typedef struct {
        logic [7:0]  w [8];
        logic [7:0]  hdr;
        logic [55:0] pay;
    } vec_t;

    vec_t       vecs [3];
    logic [7:0] cur_w [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Sends cur_w[first..7], then the XOR word when the checksum is built in.
    task automatic send_from(input int first);
        logic [7:0] x;
        for (int i = first; i < 8; i++) send_word(cur_w[i]);
`ifdef UART_MSG_DEFRAMER_CHECKSUM_EN
        x = '0;
        for (int i = 0; i < 8; i++) x = x ^ cur_w[i];
        send_word(x);
`else
        x = '0;
`endif
    endtask

    task automatic handshake(input string name);
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        chk({name, "_valid_drop"}, 64'(msg_valid), 64'd0);
    endtask

    task automatic load_words(input logic [7:0] a, b, c, d, e, f, g, h);
        cur_w[0] = a; cur_w[1] = b; cur_w[2] = c; cur_w[3] = d;
        cur_w[4] = e; cur_w[5] = f; cur_w[6] = g; cur_w[7] = h;
    endtask

    initial begin
        vecs[0].w = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        vecs[0].hdr = 8'h08;
        vecs[0].pay = 56'h07060504030201;
        vecs[1].w = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        vecs[1].hdr = 8'h80;
        vecs[1].pay = 56'h70605040302010;
        vecs[2].w = '{8'hFF, 8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h81, 8'h7E};
        vecs[2].hdr = 8'h7E;
        vecs[2].pay = 56'h813CC35AA500FF;

        // Reset state
        tick();
        tick();
        chk("rst_valid",   64'(msg_valid), 64'd0);
        chk("rst_header",  64'(msg_header), 64'd0);
        chk("rst_payload", 64'(msg_payload), 64'd0);
        chk("rst_ovf",     64'(overflow_pulse), 64'd0);
        chk("rst_to",      64'(timeout_pulse), 64'd0);
        chk("rst_csum",    64'(csum_err_pulse), 64'd0);
        chk("rst_valid16", 64'(msg_valid16), 64'd0);
        rst = 1'b0;
        tick();

        // Table-driven messages: latency, content, hold until accepted
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 8; i++) cur_w[i] = vecs[v].w[i];
            for (int i = 0; i < 7; i++) send_word(cur_w[i]);
            chk("vec_valid_early", 64'(msg_valid), 64'd0);
            send_from(7);
            chk("vec_valid",   64'(msg_valid), 64'd1);
            chk("vec_header",  64'(msg_header), 64'(vecs[v].hdr));
            chk("vec_payload", 64'(msg_payload), 64'(vecs[v].pay));
            for (int i = 0; i < 3; i++) tick();
            chk("vec_hold_valid",   64'(msg_valid), 64'd1);
            chk("vec_hold_payload", 64'(msg_payload), 64'(vecs[v].pay));
            handshake("vec");
        end

        // Timeout: 3 words then silence
        send_word(8'h99); send_word(8'h98); send_word(8'h97);
        for (int i = 0; i < TO - 1; i++) tick();
        chk("to_early", 64'(timeout_pulse), 64'd0);
        tick();
        chk("to_pulse", 64'(timeout_pulse), 64'd1);
        tick();
        chk("to_pulse_end", 64'(timeout_pulse), 64'd0);
        chk("to_no_valid", 64'(msg_valid), 64'd0);
        for (int i = 0; i < 8; i++) cur_w[i] = vecs[1].w[i];
        send_from(0);
        chk("to_next_valid",   64'(msg_valid), 64'd1);
        chk("to_next_header",  64'(msg_header), 64'h80);
        chk("to_next_payload", 64'(msg_payload), 64'h70605040302010);
        handshake("to_next");

        // Word arriving in the expiry cycle wins over the timeout
        load_words(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08);
        send_word(8'h01); send_word(8'h02); send_word(8'h03);
        for (int i = 0; i < TO - 1; i++) tick();
        send_word(8'h04);
        chk("race_no_to", 64'(timeout_pulse), 64'd0);
        send_from(4);
        chk("race_valid",   64'(msg_valid), 64'd1);
        chk("race_payload", 64'(msg_payload), 64'h07060504030201);
        handshake("race");

        // Overflow while held, then a word in the handshake cycle
        for (int i = 0; i < 8; i++) cur_w[i] = vecs[0].w[i];
        send_from(0);
        send_word(8'hAA);
        chk("ovf_pulse",   64'(overflow_pulse), 64'd1);
        chk("ovf_valid",   64'(msg_valid), 64'd1);
        chk("ovf_header",  64'(msg_header), 64'h08);
        chk("ovf_payload", 64'(msg_payload), 64'h07060504030201);
        tick();
        chk("ovf_pulse_end", 64'(overflow_pulse), 64'd0);
        msg_ready = 1'b1;
        send_word(8'hAA);
        msg_ready = 1'b0;
        chk("hs_word_valid_drop", 64'(msg_valid), 64'd0);
        chk("hs_word_no_ovf",     64'(overflow_pulse), 64'd0);
        load_words(8'hAA, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17);
        send_from(1);
        chk("hs_next_valid",   64'(msg_valid), 64'd1);
        chk("hs_next_header",  64'(msg_header), 64'h17);
        chk("hs_next_payload", 64'(msg_payload), 64'h161514131211AA);
        handshake("hs_next");

        // Reset in the middle of a message
        for (int i = 0; i < 5; i++) send_word(8'h55 + 8'(i));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid",   64'(msg_valid), 64'd0);
        chk("mid_rst_header",  64'(msg_header), 64'd0);
        chk("mid_rst_payload", 64'(msg_payload), 64'd0);
        for (int i = 0; i < 8; i++) cur_w[i] = vecs[2].w[i];
        send_from(0);
        chk("post_rst_valid",   64'(msg_valid), 64'd1);
        chk("post_rst_header",  64'(msg_header), 64'h7E);
        chk("post_rst_payload", 64'(msg_payload), 64'h813CC35AA500FF);
        handshake("post_rst");

`ifdef UART_MSG_DEFRAMER_CHECKSUM_EN
        // Correct checksum word 08, then a wrong one
        for (int i = 0; i < 8; i++) send_word(8'(i + 1));
        chk("csum_wait", 64'(msg_valid), 64'd0);
        send_word(8'h08);
        chk("csum_ok_valid", 64'(msg_valid), 64'd1);
        chk("csum_ok_err",   64'(csum_err_pulse), 64'd0);
        handshake("csum_ok");
        for (int i = 0; i < 8; i++) send_word(8'(i + 1));
        send_word(8'h00);
        chk("csum_bad_err",   64'(csum_err_pulse), 64'd1);
        chk("csum_bad_valid", 64'(msg_valid), 64'd0);
        tick();
        chk("csum_bad_err_end", 64'(csum_err_pulse), 64'd0);
        chk("csum_bad_valid2",  64'(msg_valid), 64'd0);
`endif

        // 16-bit words, 16-bit header
        begin
            logic [15:0] w16 [4];
            logic [15:0] x16;
            w16 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
            x16 = '0;
            for (int i = 0; i < 4; i++) begin
                in_data16  = w16[i];
                in_valid16 = 1'b1;
                tick();
                in_valid16 = 1'b0;
                x16 = x16 ^ w16[i];
            end
`ifdef UART_MSG_DEFRAMER_CHECKSUM_EN
            in_data16  = x16;
            in_valid16 = 1'b1;
            tick();
            in_valid16 = 1'b0;
`endif
            chk("w16_valid",   64'(msg_valid16), 64'd1);
            chk("w16_header",  64'(msg_header16), 64'h4444);
            chk("w16_payload", 64'(msg_payload16), 64'h333322221111);
            msg_ready16 = 1'b1;
            tick();
            msg_ready16 = 1'b0;
            chk("w16_valid_drop", 64'(msg_valid16), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
